// File: rtl/data_mem_hs_pkg.sv
// Shared RVX definitions for the data memory: bus width, access-size codes and FSM states.
package RVX_Info;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Reserved size reports 4 bytes; the size error already covers it.
  function automatic logic [2:0] size_bytes(size_e s);
    case (s)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_hs_load_ext.sv
// RISC-V load extender: sign- or zero-extends a byte/half from the low end of a raw word.
module load_ext
  import RVX_Info::*;
(
  input  size_e              size,
  input  logic               uns,
  input  logic [BUS_W-1:0]   raw,
  output logic [BUS_W-1:0]   data
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    data = raw;
    case (size)
      SZ_B:    data = {{(BUS_W-8){~uns & raw[7]}}, raw[7:0]};
      SZ_H:    data = {{(BUS_W-16){~uns & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request, programmable wait states,
// load extension and misalignment/range/size error reporting.
module data_mem_hs
  import RVX_Info::*;
#(
  parameter int BUS_W       = RVX_Info::BUS_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValidIn,
  output logic             reqReadyOut,
  input  logic [BUS_W-1:0] reqAddrIn,
  input  logic             reqWeIn,
  input  logic [1:0]       reqSizeIn,
  input  logic             reqUnsignedIn,
  input  logic [BUS_W-1:0] reqWDataIn,
  output logic             rspValidOut,
  output logic [BUS_W-1:0] rspRDataOut,
  output logic             rspErrOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = BUS_W + 1;

  state_e           state, state_nx;
  logic [BUS_W-1:0] addr_q, wdata_q;
  logic             we_q, uns_q;
  size_e            size_q;
  logic [3:0]       cnt_q;
  logic             accept;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    idx, i1, i2, i3;
  logic [EW-1:0]    end_addr;
  logic             err;
  logic [BUS_W-1:0] raw, ld_data;

  assign reqReadyOut = (state == ST_IDLE);
  assign accept      = reqReadyOut & reqValidIn;

  // Upper address bits only matter for the range check, which is done without wrap.
  assign idx      = addr_q[AW-1:0];
  assign i1       = idx + AW'(1);
  assign i2       = idx + AW'(2);
  assign i3       = idx + AW'(3);
  assign end_addr = {1'b0, addr_q} + EW'(size_bytes(size_q));
  assign err      = (size_q == SZ_RSV)
                 || (size_q == SZ_H && addr_q[0])
                 || (size_q == SZ_W && addr_q[1:0] != 2'b00)
                 || (end_addr > EW'(DEPTH));

  assign raw = {mem[i3], mem[i2], mem[i1], mem[idx]};

  load_ext u_load_ext (
    .size (size_q),
    .uns  (uns_q),
    .raw  (raw),
    .data (ld_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (reqValidIn) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cnt_q + 4'd1 == 4'(WAIT_CYCLES)) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      cnt_q       <= '0;
      rspValidOut <= 1'b0;
      rspRDataOut <= '0;
      rspErrOut   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= reqAddrIn;
        wdata_q <= reqWDataIn;
        we_q    <= reqWeIn;
        uns_q   <= reqUnsignedIn;
        size_q  <= size_e'(reqSizeIn);
        cnt_q   <= '0;
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q + 4'd1;
      end
      // Response registers are loaded only on the access edge, so they read zero otherwise.
      rspValidOut <= (state == ST_ACCESS);
      rspErrOut   <= (state == ST_ACCESS) && err;
      rspRDataOut <= (state == ST_ACCESS && !we_q && !err) ? ld_data : '0;
    end
  end

  // NOTE: the byte array has no reset; reset holds the FSM out of ACCESS, so no write can slip through.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && we_q && !err) begin
      mem[idx] <= wdata_q[7:0];
      if (size_q != SZ_B) mem[i1] <= wdata_q[15:8];
      if (size_q == SZ_W) begin
        mem[i2] <= wdata_q[23:16];
        mem[i3] <= wdata_q[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance without wait states, one with three.
module tb_data_mem_hs;

  localparam int W3 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld  [2];
  logic        rdy  [2];
  logic [31:0] addr [2];
  logic        we   [2];
  logic [1:0]  sz   [2];
  logic        un   [2];
  logic [31:0] wd   [2];
  logic        rv   [2];
  logic [31:0] rd   [2];
  logic        er   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.BUS_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst),
    .reqValidIn (vld[0]), .reqReadyOut (rdy[0]), .reqAddrIn (addr[0]),
    .reqWeIn (we[0]), .reqSizeIn (sz[0]), .reqUnsignedIn (un[0]), .reqWDataIn (wd[0]),
    .rspValidOut (rv[0]), .rspRDataOut (rd[0]), .rspErrOut (er[0])
  );

  data_mem_hs #(.BUS_W(32), .DEPTH(1024), .WAIT_CYCLES(W3)) u_dut3 (
    .clk (clk), .rst (rst),
    .reqValidIn (vld[1]), .reqReadyOut (rdy[1]), .reqAddrIn (addr[1]),
    .reqWeIn (we[1]), .reqSizeIn (sz[1]), .reqUnsignedIn (un[1]), .reqWDataIn (wd[1]),
    .rspValidOut (rv[1]), .rspRDataOut (rd[1]), .rspErrOut (er[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int w, input logic w_e, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    we[w] = w_e; sz[w] = s; un[w] = u; addr[w] = a; wd[w] = d;
  endtask

  // Counts negedges after the accepting edge until the pulse, then checks it lasts one cycle.
  task automatic wait_rsp(input int w, input string tag, input logic [31:0] exp_rd, input logic exp_err);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rv[w]) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), (w == 0) ? 32'd2 : 32'(W3 + 2));
    if (got) begin
      check({tag, "_data"}, rd[w], exp_rd);
      check({tag, "_err"}, {31'd0, er[w]}, {31'd0, exp_err});
      @(negedge clk);
      check({tag, "_pulse_end"}, {31'd0, rv[w]}, 32'd0);
    end
  endtask

  task automatic xact(input int w, input logic w_e, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int b;
    @(negedge clk);
    set_req(w, w_e, s, u, a, d);
    vld[w] = 1'b1;
    b = 0;
    while (!rdy[w] && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b == 50) check({tag, "_ready_timeout"}, {31'd0, rdy[w]}, 32'd1);
    @(posedge clk);
    #1 vld[w] = 1'b0;
    wait_rsp(w, tag, exp_rd, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, q, pulses;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      set_req(i, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    end

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready0", {31'd0, rdy[0]}, 32'd1);
    check("rst_valid0", {31'd0, rv[0]}, 32'd0);
    check("rst_rdata0", rd[0], 32'd0);
    check("rst_err0",   {31'd0, er[0]}, 32'd0);
    check("rst_ready3", {31'd0, rdy[1]}, 32'd1);
    rst = 1'b1;

    // Round trip and extension, no wait states
    xact(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_w_10");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w_10");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "ld_b_s");
    xact(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0, "ld_b_u");
    xact(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "ld_h_s");
    xact(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "ld_h_u");

    // Errors and boundaries
    xact(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "ld_h_mis");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "ld_w_mis");
    xact(0, 1'b1, 2'b00, 1'b0, 32'h3FE, 32'h00000077, 32'h0, 1'b0, "st_b_3fe");
    xact(0, 1'b1, 2'b00, 1'b0, 32'h3FF, 32'h00000088, 32'h0, 1'b0, "st_b_3ff");
    xact(0, 1'b1, 2'b10, 1'b0, 32'h3FE, 32'h12345678, 32'h0, 1'b1, "st_w_oor");
    xact(0, 1'b0, 2'b00, 1'b1, 32'h3FE, 32'h0, 32'h00000077, 1'b0, "ld_b_3fe");
    xact(0, 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 32'h00008877, 1'b0, "ld_h_edge");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "ld_b_400");
    xact(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size_rsv");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w_after");

    // Partial store
    xact(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0, "st_w_40");
    xact(0, 1'b1, 2'b00, 1'b0, 32'h41, 32'hDEADBEFF, 32'h0, 1'b0, "st_b_41");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1122FF44, 1'b0, "ld_w_40");

    // Wait states: a second request held high while busy is taken only after the pulse
    @(negedge clk);
    set_req(1, 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D);
    vld[1] = 1'b1;
    @(posedge clk);
    #1 set_req(1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    n = 0; p = 0; q = 0; pulses = 0;
    while (q == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (rv[1]) begin
        pulses++;
        if (p == 0) p = n;
        check("ws_st_err", {31'd0, er[1]}, 32'd0);
      end
      if (rdy[1]) q = n;
    end
    check("ws_pulse_at", 32'(p), 32'(W3 + 2));
    check("ws_ready_at", 32'(q), 32'(W3 + 3));
    check("ws_pulses",   32'(pulses), 32'd1);
    @(posedge clk);
    #1 vld[1] = 1'b0;
    wait_rsp(1, "ws_ld_80", 32'hCAFEF00D, 1'b0);

    // Reset during an outstanding store drops it
    xact(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A5A5A, 32'h0, 1'b0, "rs_pre");
    @(negedge clk);
    set_req(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA);
    vld[1] = 1'b1;
    @(posedge clk);
    #1 vld[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rs_ready", {31'd0, rdy[1]}, 32'd1);
    check("rs_valid", {31'd0, rv[1]}, 32'd0);
    check("rs_rdata", rd[1], 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    check("rs_no_rsp", 32'(pulses), 32'd0);
    xact(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h5A5A5A5A, 1'b0, "rs_ld_20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised, byte-addressed data memory for the RVX load/store unit, with a valid/ready request channel and a one-cycle response pulse.
- Adds what the plain data memory lacks:
  - configurable depth and access latency (wait states);
  - RISC-V load sign/zero extension;
  - misalignment and out-of-range error reporting;
  - a reserved-size error.
- Sits between the MEM stage and on-chip RAM. The pipeline stalls MEM while a request is outstanding.

Parameters:
- BUS_W, 32, data/address bus width in bits; only 32 is supported.
- DEPTH, 1024, memory size in bytes; must be a power of two and at least 4.
- WAIT_CYCLES, 0, extra cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- reqValidIn  input  1  request present.
- reqReadyOut  output  1  block can accept a request.
- reqAddrIn  input  BUS_W  byte address.
- reqWeIn  input  1  1 = store, 0 = load.
- reqSizeIn  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- reqUnsignedIn  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- reqWDataIn  input  BUS_W  store data, LSB-justified.
- rspValidOut  output  1  one-cycle pulse marking completion.
- rspRDataOut  output  BUS_W  extended load data; 0 for stores and errors.
- rspErrOut  output  1  request failed; valid only while rspValidOut=1.

Behaviour:
- Reset (asynchronous assert, active-low):
  - FSM goes to IDLE; rspValidOut=0, rspRDataOut=0, rspErrOut=0, wait counter=0.
  - reqReadyOut=1 once in IDLE.
  - Memory contents are not reset.
- Reset mid-operation: the outstanding request is dropped and no response is issued. A store whose commit edge has not yet occurred is never written.
- FSM states:
  - IDLE: reqReadyOut=1. On reqValidIn=1, capture addr/we/size/unsigned/wdata. Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: reqReadyOut=0. Counter counts 1..WAIT_CYCLES; go to ACCESS on the edge where it reaches WAIT_CYCLES.
  - ACCESS: reqReadyOut=0. The memory access occurs on this edge. rspValidOut, rspRDataOut and rspErrOut are registered on this edge. Go to RESP.
  - RESP: rspValidOut=1 for exactly one cycle, reqReadyOut=0. Return to IDLE. Outputs return to 0 the next cycle.
- Latency: the response pulse appears WAIT_CYCLES+2 cycles after the accepting edge. No back-to-back overlap.
- Requests while not ready: reqValidIn while reqReadyOut=0 is ignored. The requester must hold it until accepted.
- Error conditions (checked on captured fields):
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr+bytes>DEPTH, computed without wrap (addr ≥ DEPTH is an error).
- On error: no memory write, rspRDataOut=0, rspErrOut=1.
- Stores:
  - byte writes mem[addr]=wdata[7:0];
  - half writes mem[addr+1:addr]=wdata[15:0];
  - word writes 4 bytes, little-endian;
  - rspRDataOut=0.
- Loads:
  - read little-endian from the captured addr;
  - byte/half results are sign- or zero-extended to BUS_W per reqUnsignedIn;
  - word results are unchanged.
- Index width: clog2(DEPTH). Upper address bits participate only in the range check.

Decomposition:
- Shared package/include (RVX_Info): BUS_W, size encodings (SZ_B/SZ_H/SZ_W/SZ_RSV), FSM state encodings.
- Sub-module load_ext: combinational sign/zero extender taking size, unsigned and raw word. It is also reusable by the CPU's MMIO path.
- Storage stays inline as a byte array.

Test Plan:
1. Store/load round trip, WAIT_CYCLES=0: word store 0xDEADBEEF @0x10, then word load @0x10 -> rspRDataOut=0xDEADBEEF, rspErrOut=0, rspValidOut exactly 2 cycles after acceptance.
2. Extension: after test 1, byte load @0x10 signed -> 0xFFFFFFEF; unsigned -> 0x000000EF; half load @0x12 signed -> 0xFFFFDEAD.
3. Errors:
   - half load @0x11 -> rspErrOut=1, data 0;
   - word store 0x12345678 @0x3FE (DEPTH=1024) -> rspErrOut=1, and a following byte load @0x3FE returns the prior contents unchanged;
   - size=11 -> rspErrOut=1.
4. Wait states and handshake, WAIT_CYCLES=3: response 5 cycles after acceptance; reqReadyOut=0 throughout; a second reqValidIn held during busy is accepted only on the cycle after rspValidOut.
5. Reset mid-operation, WAIT_CYCLES=3: word store 0xAAAAAAAA @0x20 accepted; rst low 1 cycle later -> no rspValidOut; a subsequent load @0x20 returns the pre-reset value.
6. Partial store: word 0x11223344 @0x40, then byte store 0xFF @0x41 -> word load @0x40 = 0x1122FF44.
